// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Opcode/response bytes and FSM state encoding for the UART responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [7:0] c_op_write = 8'h57;
    localparam logic [7:0] c_op_read  = 8'h52;
    localparam logic [7:0] c_rsp_ok   = 8'h4B;
    localparam logic [7:0] c_rsp_err  = 8'h45;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GET_ADDR = 3'd1,
        S_GET_DATA = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_HI  = 3'd4,
        S_WAIT_LO  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_regfile.sv
// ============================================================================
// Module : uart_regfile
// Brief  : 8-bit register array, one synchronous write port, two async reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_regfile #(
    parameter  int NUM_REGS = 16,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [7:0]    o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [7:0]    o_rdata_b
);

    logic [7:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/uart_reg_responder.sv
// ============================================================================
// Module : uart_reg_responder
// Brief  : Byte-command register access over UART: W addr data -> K, R addr -> value.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_reg_responder
    import uart_pkg::*;
#(
    parameter  int NUM_REGS       = 16,
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int AW             = $clog2(NUM_REGS),
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy,
    input  logic [AW-1:0] user_addr,
    output logic [7:0]    user_rdata,
    output logic          rx_overrun
);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_is_write;
    logic [AW-1:0] r_addr;
    logic          r_addr_ok;
    logic [TW-1:0] r_cnt;
    logic [7:0]    r_tx_data;
    logic          r_tx_start;
    logic          r_overrun;

    logic          w_addr_ok;
    logic          w_timeout;
    logic          w_in_cmd;
    logic          w_we;
    logic          w_latch_op;
    logic          w_latch_addr;
    logic          w_load_tx;
    logic [7:0]    w_tx_byte;
    logic [7:0]    w_rd_b;
    logic          w_overrun;

    uart_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we),
        .i_waddr   (r_addr),
        .i_wdata   (rx_data),
        .i_raddr_a (user_addr),
        .o_rdata_a (user_rdata),
        .i_raddr_b (rx_data[AW-1:0]),
        .o_rdata_b (w_rd_b)
    );

    assign w_addr_ok = (int'(rx_data) < NUM_REGS);
    assign w_in_cmd  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
    // A byte arriving on the expiry cycle takes priority over the timeout
    assign w_timeout = (r_cnt == TW'(TIMEOUT_CYCLES)) && !rx_ready;
    assign w_overrun = rx_ready && ((r_state == S_SEND) || (r_state == S_WAIT_HI) ||
                                    (r_state == S_WAIT_LO));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_latch_op   = 1'b0;
        w_latch_addr = 1'b0;
        w_load_tx    = 1'b0;
        w_tx_byte    = c_rsp_err;
        case (r_state)
            S_IDLE: begin
                if (rx_ready) begin
                    if ((rx_data == c_op_write) || (rx_data == c_op_read)) begin
                        w_latch_op   = 1'b1;
                        w_state_next = S_GET_ADDR;
                    end else begin
                        w_load_tx    = 1'b1;
                        w_state_next = S_SEND;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_ready) begin
                    w_latch_addr = 1'b1;
                    if (r_is_write) begin
                        w_state_next = S_GET_DATA;
                    end else begin
                        w_load_tx    = 1'b1;
                        w_tx_byte    = w_addr_ok ? w_rd_b : c_rsp_err;
                        w_state_next = S_SEND;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (rx_ready) begin
                    w_we         = r_addr_ok;
                    w_load_tx    = 1'b1;
                    w_tx_byte    = r_addr_ok ? c_rsp_ok : c_rsp_err;
                    w_state_next = S_SEND;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_SEND: begin
                w_state_next = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    w_state_next = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_addr_ok  <= 1'b0;
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_latch_op) begin
                r_is_write <= (rx_data == c_op_write);
            end
            if (w_latch_addr) begin
                r_addr    <= rx_data[AW-1:0];
                r_addr_ok <= w_addr_ok;
            end
            if (rx_ready || !w_in_cmd || (w_state_next != r_state)) begin
                r_cnt <= '0;
            end else if (r_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_cnt <= r_cnt + TW'(1);
            end
            if (w_load_tx) begin
                r_tx_data <= w_tx_byte;
            end
            r_tx_start <= (r_state == S_SEND);
            r_overrun  <= w_overrun;
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_start   = r_tx_start;
    assign rx_overrun = r_overrun;

endmodule

`default_nettype wire
